reg_file_alu_pipe: RTL and testbench

Parametrised, two-stage pipelined successor to the register-file/ALU datapath. It holds DEPTH registers of WIDTH bits and performs an operand read stage, then an execute/writeback stage. Writeback uses an internal result-forwarding bypass, so back-to-back dependent operations issue every cycle without stalls. It sits between the instruction decode/control logic and the rest of the single-cycle-derived RISC-V datapath. It adds a richer 3-bit ALU operation set and a registered NZCV flag set.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/reg_file_mem.sv | 44 ++++
 rtl/reg_file_alu_pipe.sv | 159 +++++++++++++++
 tb/tb_reg_file_alu_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined register-file/ALU datapath: the ALU opcode
// set and the NZCV flag bundle registered alongside each result.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic Zero;
        logic Negative;
        logic Carry;
        logic Overflow;
    } alu_flags_t;

endpackage

// File: rtl/reg_file_mem.sv
// Register array with two asynchronous read ports, one synchronous write port
// and a synchronous active-low clear; register 0 can be hardwired to zero.
module reg_file_mem #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (!((ZERO_REG != 0) && (ra1 == '0))) begin
            rd1 = mem[ra1];
        end
        if (!((ZERO_REG != 0) && (ra2 == '0))) begin
            rd2 = mem[ra2];
        end
    end

    // Clear wins over a write landing on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && !((ZERO_REG != 0) && (wa == '0))) begin
            mem[wa] <= wd;
        end
    end

endmodule

// File: rtl/reg_file_alu_pipe.sv
// Two-stage register-file/ALU pipeline: operand read, then execute/writeback,
// with an EX-result bypass so dependent operations can issue every cycle.
module reg_file_alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             in_valid,
    input  logic [AW-1:0]    RA1,
    input  logic [AW-1:0]    RA2,
    input  logic [AW-1:0]    WA,
    input  logic [WIDTH-1:0] immediate,
    input  logic             write_enable,
    input  logic             ALUSrc,
    input  logic [2:0]       ALUControl,
    output logic             out_valid,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] cpu_out,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow
);

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             ex_valid;
    logic [WIDTH-1:0] ex_opa;
    logic [WIDTH-1:0] ex_regb;
    logic [WIDTH-1:0] ex_imm;
    logic             ex_alusrc;
    alu_op_e          ex_op;
    logic [AW-1:0]    ex_wa;
    logic             ex_we;

    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] opa_next;
    logic [WIDTH-1:0] regb_next;
    logic             ex_commit;

    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    alu_flags_t       alu_flags;
    alu_flags_t       flags_q;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [SHW-1:0]   shamt;

    assign ex_commit = ex_valid && ex_we && !((ZERO_REG != 0) && (ex_wa == '0));

    reg_file_mem #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_mem (
        .clk     (CLK),
        .reset_n (RESET_N),
        .we      (ex_commit),
        .wa      (ex_wa),
        .wd      (alu_result),
        .ra1     (RA1),
        .ra2     (RA2),
        .rd1     (rd1),
        .rd2     (rd2)
    );

    // The EX result is not in the array until this edge, so forward it.
    always_comb begin
        opa_next  = rd1;
        regb_next = rd2;
        if (ex_commit && (ex_wa == RA1)) begin
            opa_next = alu_result;
        end
        if (ex_commit && (ex_wa == RA2)) begin
            regb_next = alu_result;
        end
    end

    always_comb begin
        alu_b      = ex_alusrc ? ex_imm : ex_regb;
        sum_ext    = {1'b0, ex_opa} + {1'b0, alu_b};
        diff_ext   = {1'b0, ex_opa} - {1'b0, alu_b};
        shamt      = alu_b[SHW-1:0];
        alu_result = '0;
        alu_flags  = '0;
        case (ex_op)
            ALU_ADD: begin
                alu_result         = sum_ext[WIDTH-1:0];
                alu_flags.Carry    = sum_ext[WIDTH];
                alu_flags.Overflow = (ex_opa[WIDTH-1] == alu_b[WIDTH-1]) &&
                                     (sum_ext[WIDTH-1] != ex_opa[WIDTH-1]);
            end
            ALU_SUB: begin
                // Bit WIDTH of the extended difference is the borrow.
                alu_result         = diff_ext[WIDTH-1:0];
                alu_flags.Carry    = ~diff_ext[WIDTH];
                alu_flags.Overflow = (ex_opa[WIDTH-1] != alu_b[WIDTH-1]) &&
                                     (diff_ext[WIDTH-1] != ex_opa[WIDTH-1]);
            end
            ALU_AND: alu_result = ex_opa & alu_b;
            ALU_OR:  alu_result = ex_opa | alu_b;
            ALU_XOR: alu_result = ex_opa ^ alu_b;
            ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, ($signed(ex_opa) < $signed(alu_b))};
            ALU_SLL: alu_result = ex_opa << shamt;
            ALU_SRL: alu_result = ex_opa >> shamt;
            default: alu_result = '0;
        endcase
        alu_flags.Zero     = (alu_result == '0);
        alu_flags.Negative = alu_result[WIDTH-1];
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ex_valid  <= 1'b0;
            ex_opa    <= '0;
            ex_regb   <= '0;
            ex_imm    <= '0;
            ex_alusrc <= 1'b0;
            ex_op     <= ALU_ADD;
            ex_wa     <= '0;
            ex_we     <= 1'b0;
            out_valid <= 1'b0;
            ALUResult <= '0;
            cpu_out   <= '0;
            flags_q   <= '0;
        end else begin
            ex_valid  <= in_valid;
            out_valid <= ex_valid;
            if (in_valid) begin
                ex_opa    <= opa_next;
                ex_regb   <= regb_next;
                ex_imm    <= immediate;
                ex_alusrc <= ALUSrc;
                ex_op     <= alu_op_e'(ALUControl);
                ex_wa     <= WA;
                ex_we     <= write_enable;
            end
            if (ex_valid) begin
                ALUResult <= alu_result;
                cpu_out   <= ex_regb;
                flags_q   <= alu_flags;
            end
        end
    end

    assign Zero     = flags_q.Zero;
    assign Negative = flags_q.Negative;
    assign Carry    = flags_q.Carry;
    assign Overflow = flags_q.Overflow;

endmodule

// File: tb/tb_reg_file_alu_pipe.sv
// Directed bench for reg_file_alu_pipe: a table of single operations with
// hand-computed results, plus sequences for forwarding, r0 and reset corners.
module tb_reg_file_alu_pipe;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       in_valid;
    logic [3:0] RA1, RA2, WA;
    logic [7:0] immediate;
    logic       write_enable;
    logic       ALUSrc;
    logic [2:0] ALUControl;
    logic       out_valid;
    logic [7:0] ALUResult;
    logic [7:0] cpu_out;
    logic       Zero, Negative, Carry, Overflow;

    int total = 0;
    int bad   = 0;

    reg_file_alu_pipe #(.WIDTH(8), .DEPTH(16), .ZERO_REG(1)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .in_valid     (in_valid),
        .RA1          (RA1),
        .RA2          (RA2),
        .WA           (WA),
        .immediate    (immediate),
        .write_enable (write_enable),
        .ALUSrc       (ALUSrc),
        .ALUControl   (ALUControl),
        .out_valid    (out_valid),
        .ALUResult    (ALUResult),
        .cpu_out      (cpu_out),
        .Zero         (Zero),
        .Negative     (Negative),
        .Carry        (Carry),
        .Overflow     (Overflow)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] op;
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic       alusrc;
        logic [7:0] imm;
        logic       we;
        logic [3:0] wa;
        logic [7:0] exp_res;
        logic [3:0] exp_zncv;
        logic [7:0] exp_cpu;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [2:0] op, logic [3:0] ra1, logic [3:0] ra2,
                                logic alusrc, logic [7:0] imm, logic we, logic [3:0] wa,
                                logic [7:0] exp_res, logic [3:0] exp_zncv, logic [7:0] exp_cpu);
        vec_t v;
        v.op = op; v.ra1 = ra1; v.ra2 = ra2; v.alusrc = alusrc; v.imm = imm;
        v.we = we; v.wa = wa; v.exp_res = exp_res; v.exp_zncv = exp_zncv; v.exp_cpu = exp_cpu;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic [2:0] op, input logic [3:0] ra1, input logic [3:0] ra2,
                            input logic alusrc, input logic [7:0] imm, input logic we,
                            input logic [3:0] wa);
        in_valid     = 1'b1;
        ALUControl   = op;
        RA1          = ra1;
        RA2          = ra2;
        ALUSrc       = alusrc;
        immediate    = imm;
        write_enable = we;
        WA           = wa;
    endtask

    task automatic check_result(input string tag, input logic [7:0] res,
                                input logic [3:0] zncv, input logic [7:0] cpu);
        check_output({tag, " out_valid"}, {15'd0, out_valid}, 16'd1);
        check_output({tag, " result"}, {8'd0, ALUResult}, {8'd0, res});
        check_output({tag, " zncv"}, {12'd0, Zero, Negative, Carry, Overflow}, {12'd0, zncv});
        check_output({tag, " cpu_out"}, {8'd0, cpu_out}, {8'd0, cpu});
    endtask

    // One isolated operation: issue, idle one cycle, sample after the retire edge.
    task automatic apply_stimulus(input int idx);
        vec_t v;
        v = vecs[idx];
        @(negedge CLK);
        drive_op(v.op, v.ra1, v.ra2, v.alusrc, v.imm, v.we, v.wa);
        @(negedge CLK);
        in_valid = 1'b0;
        @(negedge CLK);
        check_result($sformatf("vec%0d", idx), v.exp_res, v.exp_zncv, v.exp_cpu);
    endtask

    initial begin
        // op, ra1, ra2, alusrc, imm, we, wa, result, ZNCV, cpu_out
        vecs.push_back(mk(3'd0, 4'd3, 4'd5, 1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 4'b1000, 8'h00));
        vecs.push_back(mk(3'd0, 4'd0, 4'd0, 1'b1, 8'h05, 1'b1, 4'd1, 8'h05, 4'b0000, 8'h00));
        vecs.push_back(mk(3'd0, 4'd0, 4'd0, 1'b1, 8'h0A, 1'b1, 4'd2, 8'h0A, 4'b0000, 8'h00));
        vecs.push_back(mk(3'd1, 4'd1, 4'd2, 1'b0, 8'h00, 1'b0, 4'd0, 8'hFB, 4'b0100, 8'h0A));
        vecs.push_back(mk(3'd1, 4'd2, 4'd1, 1'b1, 8'h05, 1'b0, 4'd0, 8'h05, 4'b0010, 8'h05));
        vecs.push_back(mk(3'd0, 4'd0, 4'd0, 1'b1, 8'h7F, 1'b1, 4'd3, 8'h7F, 4'b0000, 8'h00));
        vecs.push_back(mk(3'd0, 4'd3, 4'd0, 1'b1, 8'h01, 1'b0, 4'd0, 8'h80, 4'b0101, 8'h00));
        vecs.push_back(mk(3'd0, 4'd0, 4'd0, 1'b1, 8'hFF, 1'b1, 4'd4, 8'hFF, 4'b0100, 8'h00));
        vecs.push_back(mk(3'd0, 4'd4, 4'd0, 1'b1, 8'h01, 1'b0, 4'd0, 8'h00, 4'b1010, 8'h00));
        vecs.push_back(mk(3'd1, 4'd3, 4'd4, 1'b0, 8'h00, 1'b0, 4'd0, 8'h80, 4'b0101, 8'hFF));
        vecs.push_back(mk(3'd0, 4'd0, 4'd0, 1'b1, 8'h01, 1'b1, 4'd5, 8'h01, 4'b0000, 8'h00));
        vecs.push_back(mk(3'd5, 4'd4, 4'd5, 1'b0, 8'h00, 1'b0, 4'd0, 8'h01, 4'b0000, 8'h01));
        vecs.push_back(mk(3'd5, 4'd5, 4'd4, 1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 4'b1000, 8'hFF));
        vecs.push_back(mk(3'd0, 4'd0, 4'd0, 1'b1, 8'h81, 1'b1, 4'd6, 8'h81, 4'b0100, 8'h00));
        vecs.push_back(mk(3'd6, 4'd6, 4'd0, 1'b1, 8'h03, 1'b0, 4'd0, 8'h08, 4'b0000, 8'h00));
        vecs.push_back(mk(3'd7, 4'd6, 4'd0, 1'b1, 8'h03, 1'b0, 4'd0, 8'h10, 4'b0000, 8'h00));
        vecs.push_back(mk(3'd7, 4'd6, 4'd0, 1'b1, 8'h0B, 1'b0, 4'd0, 8'h10, 4'b0000, 8'h00));
        vecs.push_back(mk(3'd0, 4'd0, 4'd0, 1'b1, 8'hF0, 1'b1, 4'd7, 8'hF0, 4'b0100, 8'h00));
        vecs.push_back(mk(3'd4, 4'd7, 4'd0, 1'b1, 8'h3C, 1'b0, 4'd0, 8'hCC, 4'b0100, 8'h00));
        vecs.push_back(mk(3'd2, 4'd7, 4'd0, 1'b1, 8'h3C, 1'b0, 4'd0, 8'h30, 4'b0000, 8'h00));
        vecs.push_back(mk(3'd3, 4'd7, 4'd0, 1'b1, 8'h3C, 1'b0, 4'd0, 8'hFC, 4'b0100, 8'h00));
        vecs.push_back(mk(3'd0, 4'd0, 4'd0, 1'b1, 8'h55, 1'b1, 4'd0, 8'h55, 4'b0000, 8'h00));
        vecs.push_back(mk(3'd0, 4'd0, 4'd0, 1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 4'b1000, 8'h00));

        RESET_N = 1'b0;
        drive_op(3'd0, 4'd0, 4'd0, 1'b0, 8'h00, 1'b0, 4'd0);
        in_valid = 1'b0;
        repeat (3) @(negedge CLK);
        check_output("reset out_valid", {15'd0, out_valid}, 16'd0);
        check_output("reset result", {8'd0, ALUResult}, 16'd0);
        check_output("reset zncv", {12'd0, Zero, Negative, Carry, Overflow}, 16'd0);
        check_output("reset cpu_out", {8'd0, cpu_out}, 16'd0);
        RESET_N = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(i);
        end

        // Back-to-back dependent issue: r8 <- r0+5, then r9 <- r8+5 with r8 also on RA2.
        @(negedge CLK);
        drive_op(3'd0, 4'd0, 4'd0, 1'b1, 8'h05, 1'b1, 4'd8);
        @(negedge CLK);
        drive_op(3'd0, 4'd8, 4'd8, 1'b1, 8'h05, 1'b1, 4'd9);
        @(negedge CLK);
        in_valid = 1'b0;
        check_result("fwd first", 8'h05, 4'b0000, 8'h00);
        @(negedge CLK);
        check_result("fwd second", 8'h0A, 4'b0000, 8'h05);
        @(negedge CLK);
        check_output("fwd idle out_valid", {15'd0, out_valid}, 16'd0);
        check_output("fwd idle hold", {8'd0, ALUResult}, 16'h000A);
        drive_op(3'd0, 4'd9, 4'd8, 1'b1, 8'h00, 1'b0, 4'd0);
        @(negedge CLK);
        in_valid = 1'b0;
        @(negedge CLK);
        check_result("read r9", 8'h0A, 4'b0000, 8'h05);

        // A write to r0 must not be forwarded to the very next reader.
        @(negedge CLK);
        drive_op(3'd0, 4'd0, 4'd0, 1'b1, 8'h55, 1'b1, 4'd0);
        @(negedge CLK);
        drive_op(3'd0, 4'd0, 4'd0, 1'b0, 8'h00, 1'b0, 4'd0);
        @(negedge CLK);
        in_valid = 1'b0;
        check_result("r0 write", 8'h55, 4'b0000, 8'h00);
        @(negedge CLK);
        check_result("r0 no bypass", 8'h00, 4'b1000, 8'h00);

        // Reset lands while r4 <- 9 is in EX; an op offered during reset is ignored.
        @(negedge CLK);
        drive_op(3'd0, 4'd0, 4'd0, 1'b1, 8'h09, 1'b1, 4'd4);
        @(negedge CLK);
        RESET_N = 1'b0;
        drive_op(3'd0, 4'd0, 4'd0, 1'b1, 8'h07, 1'b1, 4'd5);
        @(negedge CLK);
        check_output("rst discard out_valid", {15'd0, out_valid}, 16'd0);
        check_output("rst discard result", {8'd0, ALUResult}, 16'd0);
        RESET_N = 1'b1;
        in_valid = 1'b0;
        @(negedge CLK);
        check_output("rst ignored out_valid", {15'd0, out_valid}, 16'd0);
        @(negedge CLK);
        check_output("rst ignored out_valid2", {15'd0, out_valid}, 16'd0);
        drive_op(3'd0, 4'd4, 4'd5, 1'b0, 8'h00, 1'b0, 4'd0);
        @(negedge CLK);
        in_valid = 1'b0;
        @(negedge CLK);
        check_result("r4 after reset", 8'h00, 4'b1000, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
